// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and helpers for the VGA pixel output stage.
//                Default channel widths, fade-level constants, sync-level
//                constants and the default palette entry builder.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int IDX_W_DEF = 3;
    localparam int R_W_DEF   = 5;
    localparam int G_W_DEF   = 6;
    localparam int B_W_DEF   = 5;

    localparam int             FADE_W   = 4;
    localparam logic [FADE_W-1:0] FADE_MAX = 4'd15;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Default palette entry selector for index idx: bit 0 drives red, bit 1
    // green, bit 2 blue. Index bits that do not exist (idx_w < 3) read as 0,
    // and bits above 2 play no part. The caller replicates each selector bit
    // across its channel width to form the full entry.
    function automatic logic [2:0] default_entry_sel(input int unsigned idx,
                                                     input int unsigned idx_w);
        logic [2:0] sel;
        sel = 3'b000;
        for (int b = 0; b < 3; b++) begin
            if (b < idx_w) begin
                sel[b] = idx[b];
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_palette_ram.sv
`default_nettype none
// ============================================================================
//  Module      : vga_palette_ram
//  Description : Writable palette register file, 2**IDX_W entries of
//                {red, green, blue}. One synchronous write port, one
//                combinational read port. Asynchronous reset restores the
//                3-bit-to-RGB replication defaults.
//  Ports       : clk, reset        - clock, async active-high reset
//                we/wr_addr/wr_data- write port
//                rd_addr/rd_data   - combinational read port
//  Revision    : 1.0  initial release
// ============================================================================
module vga_palette_ram
    import vga_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int R_W   = R_W_DEF,
    parameter int G_W   = G_W_DEF,
    parameter int B_W   = B_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [R_W+G_W+B_W-1:0] wr_data,
    input  logic [IDX_W-1:0]       rd_addr,
    output logic [R_W+G_W+B_W-1:0] rd_data
);

    localparam int DATA_W = R_W + G_W + B_W;
    localparam int DEPTH  = 2 ** IDX_W;

    logic [DATA_W-1:0] w_mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [2:0]        c_def_sel   = default_entry_sel(i, IDX_W);
        localparam logic [DATA_W-1:0] c_def_entry = {{R_W{c_def_sel[0]}},
                                                     {G_W{c_def_sel[1]}},
                                                     {B_W{c_def_sel[2]}}};
        logic [DATA_W-1:0] r_entry;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_entry <= c_def_entry;
            end else if (we && (wr_addr == IDX_W'(i))) begin
                r_entry <= wr_data;
            end
        end

        assign w_mem[i] = r_entry;
    end

    // Read sees the pre-write contents during the write cycle, so a pixel
    // sampled on the same edge as a write gets the old colour.
    assign rd_data = w_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/vga_palette_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_palette_out
//  Description : Pixel output stage. Two-stage pipeline: stage 1 registers
//                the index, active flag and syncs; stage 2 registers the
//                palette colour (blanked when inactive) and the delayed
//                syncs. frame_start pulses once per vsync assertion.
//  Ports       : clk, reset (async active-high)
//                pix_idx, pix_active, hsync_in, vsync_in - pixel stream in
//                pal_we, pal_addr, pal_data              - palette write
//                hsync, vsync, red, green, blue          - video out
//                frame_start                             - frame pulse
//                fade_target                             - fade level goal
//  Options     : VGA_FADE_EN - adds fade_target port and per-frame
//                brightness stepping applied in stage 2.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_palette_out
    import vga_pkg::*;
#(
    parameter int   IDX_W    = IDX_W_DEF,
    parameter int   R_W      = R_W_DEF,
    parameter int   G_W      = G_W_DEF,
    parameter int   B_W      = B_W_DEF,
    parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IDX_W-1:0]       pix_idx,
    input  logic                   pix_active,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   pal_we,
    input  logic [IDX_W-1:0]       pal_addr,
    input  logic [R_W+G_W+B_W-1:0] pal_data,
`ifdef VGA_FADE_EN
    input  logic [FADE_W-1:0]      fade_target,
`endif
    output logic                   hsync,
    output logic                   vsync,
    output logic [R_W-1:0]         red,
    output logic [G_W-1:0]         green,
    output logic [B_W-1:0]         blue,
    output logic                   frame_start
);

    localparam int DATA_W = R_W + G_W + B_W;

    // ---------------- stage 1 ----------------
    logic [IDX_W-1:0] r_idx_s1;
    logic             r_active_s1;
    logic             r_hsync_s1;
    logic             r_vsync_s1;
    logic             r_frame_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx_s1      <= '0;
            r_active_s1   <= 1'b0;
            r_hsync_s1    <= ~SYNC_POL;
            r_vsync_s1    <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_idx_s1      <= pix_idx;
            r_active_s1   <= pix_active;
            r_hsync_s1    <= hsync_in;
            r_vsync_s1    <= vsync_in;
            // Edge detect against the previous registered vsync, so a held
            // assertion produces only one pulse.
            r_frame_start <= (vsync_in == SYNC_POL) && (r_vsync_s1 != SYNC_POL);
        end
    end

    // ---------------- palette ----------------
    logic [DATA_W-1:0] w_pal_rd;

    vga_palette_ram #(
        .IDX_W (IDX_W),
        .R_W   (R_W),
        .G_W   (G_W),
        .B_W   (B_W)
    ) u_palette (
        .clk     (clk),
        .reset   (reset),
        .we      (pal_we),
        .wr_addr (pal_addr),
        .wr_data (pal_data),
        .rd_addr (r_idx_s1),
        .rd_data (w_pal_rd)
    );

    logic [R_W-1:0] w_red_pal;
    logic [G_W-1:0] w_green_pal;
    logic [B_W-1:0] w_blue_pal;

    assign w_red_pal   = w_pal_rd[DATA_W-1 -: R_W];
    assign w_green_pal = w_pal_rd[B_W +: G_W];
    assign w_blue_pal  = w_pal_rd[B_W-1:0];

    logic [R_W-1:0] w_red_col;
    logic [G_W-1:0] w_green_col;
    logic [B_W-1:0] w_blue_col;

`ifdef VGA_FADE_EN
    // ---------------- fade ----------------
    logic [FADE_W-1:0] r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= FADE_MAX;
        end else if (r_frame_start) begin
            if (r_level < fade_target) begin
                r_level <= r_level + 1'b1;
            end else if (r_level > fade_target) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Scale = (colour * (level+1)) >> FADE_W. level+1 spans 1..16, so the
    // product never exceeds channel width + FADE_W bits.
    logic [FADE_W:0]       w_lvl_p1;
    logic [R_W+FADE_W:0]   w_red_prod;
    logic [G_W+FADE_W:0]   w_green_prod;
    logic [B_W+FADE_W:0]   w_blue_prod;

    assign w_lvl_p1     = {1'b0, r_level} + (FADE_W+1)'(1);
    assign w_red_prod   = (R_W+FADE_W+1)'(w_red_pal)   * (R_W+FADE_W+1)'(w_lvl_p1);
    assign w_green_prod = (G_W+FADE_W+1)'(w_green_pal) * (G_W+FADE_W+1)'(w_lvl_p1);
    assign w_blue_prod  = (B_W+FADE_W+1)'(w_blue_pal)  * (B_W+FADE_W+1)'(w_lvl_p1);

    assign w_red_col    = w_red_prod[R_W+FADE_W-1:FADE_W];
    assign w_green_col  = w_green_prod[G_W+FADE_W-1:FADE_W];
    assign w_blue_col   = w_blue_prod[B_W+FADE_W-1:FADE_W];
`else
    assign w_red_col    = w_red_pal;
    assign w_green_col  = w_green_pal;
    assign w_blue_col   = w_blue_pal;
`endif

    // ---------------- stage 2 ----------------
    logic [R_W-1:0] r_red;
    logic [G_W-1:0] r_green;
    logic [B_W-1:0] r_blue;
    logic           r_hsync_s2;
    logic           r_vsync_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_red      <= '0;
            r_green    <= '0;
            r_blue     <= '0;
            r_hsync_s2 <= ~SYNC_POL;
            r_vsync_s2 <= ~SYNC_POL;
        end else begin
            r_red      <= r_active_s1 ? w_red_col   : '0;
            r_green    <= r_active_s1 ? w_green_col : '0;
            r_blue     <= r_active_s1 ? w_blue_col  : '0;
            r_hsync_s2 <= r_hsync_s1;
            r_vsync_s2 <= r_vsync_s1;
        end
    end

    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign hsync       = r_hsync_s2;
    assign vsync       = r_vsync_s2;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_palette_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_palette_out
//  Description : Directed self-checking bench for vga_palette_out with the
//                default parameters (3-bit index, 565 output, active-low
//                syncs). Fade checks are included when VGA_FADE_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_palette_out;

    logic        clk;
    logic        reset;
    logic [2:0]  pix_idx;
    logic        pix_active;
    logic        hsync_in;
    logic        vsync_in;
    logic        pal_we;
    logic [2:0]  pal_addr;
    logic [15:0] pal_data;
`ifdef VGA_FADE_EN
    logic [3:0]  fade_target;
`endif
    logic        hsync;
    logic        vsync;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        frame_start;

    int n_total;
    int n_pass;
    int n_fail;

    vga_palette_out dut (
        .clk         (clk),
        .reset       (reset),
        .pix_idx     (pix_idx),
        .pix_active  (pix_active),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pal_we      (pal_we),
        .pal_addr    (pal_addr),
        .pal_data    (pal_data),
`ifdef VGA_FADE_EN
        .fade_target (fade_target),
`endif
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rgb(input string tag, input logic [4:0] r, input logic [5:0] g,
                           input logic [4:0] b);
        chk({tag, ".red"},   32'(red),   32'(r));
        chk({tag, ".green"}, 32'(green), 32'(g));
        chk({tag, ".blue"},  32'(blue),  32'(b));
    endtask

    initial begin
        logic prev_h;
        int   low_cnt;
        int   fs_cnt;

        n_total = 0; n_pass = 0; n_fail = 0;
        reset = 1'b1; pix_idx = 3'd0; pix_active = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        pal_we = 1'b0; pal_addr = 3'd0; pal_data = 16'h0;
`ifdef VGA_FADE_EN
        fade_target = 4'd15;
`endif
        tick(3);

        // Reset state
        chk_rgb("reset", 5'h00, 6'h00, 5'h00);
        chk("reset.hsync", 32'(hsync), 32'd1);
        chk("reset.vsync", 32'(vsync), 32'd1);
        chk("reset.frame_start", 32'(frame_start), 32'd0);

        // Default palette lookups
        reset = 1'b0;
        pix_idx = 3'd5; pix_active = 1'b1;
        tick(2);
        chk_rgb("idx5", 5'h1F, 6'h00, 5'h1F);
        pix_idx = 3'd2;
        tick(2);
        chk_rgb("idx2", 5'h00, 6'h3F, 5'h00);
        pix_idx = 3'd1;
        tick(2);
        chk_rgb("idx1", 5'h1F, 6'h00, 5'h00);

        // Blanking
        pix_idx = 3'd7; pix_active = 1'b0;
        tick(2);
        chk_rgb("blank7", 5'h00, 6'h00, 5'h00);
        pix_active = 1'b1;
        tick(2);
        chk_rgb("active7", 5'h1F, 6'h3F, 5'h1F);

        // hsync 96-cycle pulse, delayed two pipeline stages
        prev_h  = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            hsync_in = (i >= 4 && i < 100) ? 1'b0 : 1'b1;
            tick(1);
            chk("hsync.delay", 32'(hsync), 32'(prev_h));
            if (hsync == 1'b0) low_cnt++;
            prev_h = hsync_in;
        end
        chk("hsync.width", 32'(low_cnt), 32'd96);

        // Write/read collision on entry 3
        pix_idx = 3'd3; pix_active = 1'b1;
        tick(2);
        chk_rgb("idx3.default", 5'h1F, 6'h3F, 5'h00);
        pal_we = 1'b1; pal_addr = 3'd3; pal_data = {5'h10, 6'h20, 5'h01};
        tick(1);
        pal_we = 1'b0;
        chk_rgb("collide.old", 5'h1F, 6'h3F, 5'h00);
        tick(1);
        chk_rgb("collide.new", 5'h10, 6'h20, 5'h01);
        pix_idx = 3'd1;
        tick(2);
        chk_rgb("idx1.untouched", 5'h1F, 6'h00, 5'h00);

        // vsync held low for two lines -> single frame_start
        fs_cnt = 0;
        vsync_in = 1'b0;
        tick(1);
        chk("frame_start.first", 32'(frame_start), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (frame_start) fs_cnt++;
            if (i == 1) chk("vsync.delayed", 32'(vsync), 32'd0);
            tick(1);
        end
        vsync_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (frame_start) fs_cnt++;
            tick(1);
        end
        chk("frame_start.count", 32'(fs_cnt), 32'd1);
        chk("vsync.released", 32'(vsync), 32'd1);

        // Reset mid-line with modified palette
        pix_idx = 3'd3; pix_active = 1'b1; hsync_in = 1'b0;
        tick(2);
        chk_rgb("pre_reset", 5'h10, 6'h20, 5'h01);
        chk("pre_reset.hsync", 32'(hsync), 32'd0);
        reset = 1'b1;
        #1;
        chk_rgb("async_reset", 5'h00, 6'h00, 5'h00);
        chk("async_reset.hsync", 32'(hsync), 32'd1);
        tick(1);
        reset = 1'b0; hsync_in = 1'b1;
        tick(2);
        chk_rgb("post_reset.idx3", 5'h1F, 6'h3F, 5'h00);

`ifdef VGA_FADE_EN
        // Fade full white down to level 0
        pix_idx = 3'd7; pix_active = 1'b1;
        tick(2);
        chk_rgb("fade.full", 5'h1F, 6'h3F, 5'h1F);
        fade_target = 4'd0;
        for (int k = 0; k < 15; k++) begin
            vsync_in = 1'b0; tick(1);
            vsync_in = 1'b1; tick(2);
            if (k == 0) chk_rgb("fade.lvl14", 5'h1D, 6'h3B, 5'h1D);
        end
        tick(2);
        chk_rgb("fade.lvl0", 5'h01, 6'h03, 5'h01);
        vsync_in = 1'b0; tick(1);
        vsync_in = 1'b1; tick(4);
        chk_rgb("fade.hold0", 5'h01, 6'h03, 5'h01);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
